// File: rtl/serial_shifter.sv
// serial_shifter: multi-cycle shift/rotate unit (one bit per clock) with a START/BUSY/DONE handshake.
// Define SERIAL_SHIFTER_FAST_COUNT_EN to clamp step counts at acceptance (worst-case latency 10 cycles).
module serial_shifter (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic [7:0] INPUT,
    input  logic [7:0] SHIFT_AMNT,
    input  logic [1:0] SHIFTOP,
    output logic       BUSY,
    output logic       DONE,
    output logic [7:0] OUTPUT
);
    localparam logic [1:0] OP_SRL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_SLL = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t     state, state_next;
    logic [7:0] work;
    logic [3:0] cnt;
    logic [1:0] op;
    logic [3:0] eff_cnt;
    logic       accept;
    logic       unused_amnt;

    assign unused_amnt = ^SHIFT_AMNT[7:4];

    function automatic logic [7:0] shift_step(input logic [1:0] f_op, input logic [7:0] r);
        logic signed [7:0] rs;
        rs = r;
        case (f_op)
            OP_SRL:  shift_step = {1'b0, r[7:1]};
            OP_SRA:  shift_step = $unsigned(rs >>> 1);
            OP_ROR:  shift_step = {r[0], r[7:1]};
            OP_SLL:  shift_step = {r[6:0], 1'b0};
            default: shift_step = r;
        endcase
    endfunction

`ifdef SERIAL_SHIFTER_FAST_COUNT_EN
    // Beyond 8 steps srl/sll/sra saturate and ror repeats, so shorter counts give identical results.
    assign eff_cnt = (SHIFTOP == OP_ROR) ? {1'b0, SHIFT_AMNT[2:0]}
                   : (SHIFT_AMNT[3] ? 4'd8 : SHIFT_AMNT[3:0]);
`else
    assign eff_cnt = SHIFT_AMNT[3:0];
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FINISH accepts START exactly like IDLE so operations can run back-to-back.
    always_comb begin
        state_next = state;
        BUSY       = 1'b0;
        DONE       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                BUSY = 1'b1;
                if (cnt == 4'd0) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                DONE = 1'b1;
                if (START) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            work   <= 8'h00;
            cnt    <= 4'd0;
            op     <= 2'b00;
            OUTPUT <= 8'h00;
        end else begin
            if (accept) begin
                work <= INPUT;
                cnt  <= eff_cnt;
                op   <= SHIFTOP;
            end else if (state == SHIFT && cnt != 4'd0) begin
                work <= shift_step(op, work);
                cnt  <= cnt - 4'd1;
            end
            if (state == SHIFT && cnt == 4'd0) begin
                OUTPUT <= work;
            end
        end
    end
endmodule

// File: tb/tb_serial_shifter.sv
// Bench for serial_shifter: directed and random operations checked against an arithmetic reference model.
module tb_serial_shifter;
    logic       CLK;
    logic       RESET;
    logic       START;
    logic [7:0] INPUT;
    logic [7:0] SHIFT_AMNT;
    logic [1:0] SHIFTOP;
    logic       BUSY;
    logic       DONE;
    logic [7:0] OUTPUT;

    int n_checks = 0;
    int n_fail   = 0;

    serial_shifter dut (
        .CLK(CLK), .RESET(RESET), .START(START), .INPUT(INPUT),
        .SHIFT_AMNT(SHIFT_AMNT), .SHIFTOP(SHIFTOP),
        .BUSY(BUSY), .DONE(DONE), .OUTPUT(OUTPUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Result from the arithmetic meaning of each operation, count = SHIFT_AMNT mod 16.
    function automatic logic [7:0] model(input logic [1:0] op, input logic [7:0] x, input logic [7:0] amnt);
        int n, xi, sx, k, r;
        n  = int'(amnt) % 16;
        xi = int'(x);
        r  = 0;
        case (op)
            2'b00: r = xi >> n;
            2'b01: begin
                sx = (xi >= 128) ? xi - 256 : xi;
                r  = sx >>> n;
            end
            2'b10: begin
                k = n % 8;
                r = (xi >> k) | (xi << (8 - k));
            end
            default: r = xi << n;
        endcase
        return 8'(r & 255);
    endfunction

    function automatic int exp_count(input logic [1:0] op, input logic [7:0] amnt);
        int n;
        n = int'(amnt) % 16;
`ifdef SERIAL_SHIFTER_FAST_COUNT_EN
        if (op == 2'b10) n = n % 8;
        else if (n > 8)  n = 8;
`else
        if (op == 2'b10) n = n + 0;
`endif
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one operation at the current negedge and follow it to DONE.
    task automatic do_op(input logic [1:0] op, input logic [7:0] x, input logic [7:0] amnt,
                         input bit poke, input bit chain);
        logic [7:0] exp_out, prev;
        int n, lat, busy_cnt;
        bit stable;
        exp_out  = model(op, x, amnt);
        n        = exp_count(op, amnt);
        prev     = OUTPUT;
        stable   = 1'b1;
        lat      = 1;
        busy_cnt = 0;
        START = 1'b1; INPUT = x; SHIFT_AMNT = amnt; SHIFTOP = op;
        @(negedge CLK);
        START = 1'b0;
        INPUT = 8'($urandom); SHIFT_AMNT = 8'($urandom); SHIFTOP = 2'($urandom);
        chk("busy_first_cycle", {31'd0, BUSY}, 32'd1);
        while (DONE !== 1'b1 && lat < 40) begin
            if (BUSY === 1'b1) busy_cnt++;
            if (OUTPUT !== prev) stable = 1'b0;
            if (poke && lat == 1) begin
                START = 1'b1;
                INPUT = ~x;
            end else begin
                START = 1'b0;
            end
            @(negedge CLK);
            lat++;
        end
        START = 1'b0;
        chk("latency", lat, n + 2);
        chk("busy_cycles", busy_cnt, n + 1);
        chk("output_stable_while_busy", {31'd0, stable}, 32'd1);
        chk("result", {24'd0, OUTPUT}, {24'd0, exp_out});
        chk("busy_low_at_done", {31'd0, BUSY}, 32'd0);
        if (!chain) begin
            @(negedge CLK);
            chk("done_single_pulse", {31'd0, DONE}, 32'd0);
            chk("result_held", {24'd0, OUTPUT}, {24'd0, exp_out});
        end
    endtask

    initial begin
        bit done_seen;
        bit chain;
        RESET = 1'b1; START = 1'b0; INPUT = 8'h00; SHIFT_AMNT = 8'h00; SHIFTOP = 2'b00;
        @(negedge CLK);
        @(negedge CLK);
        chk("reset_output", {24'd0, OUTPUT}, 32'd0);
        chk("reset_busy", {31'd0, BUSY}, 32'd0);
        chk("reset_done", {31'd0, DONE}, 32'd0);
        RESET = 1'b0;
        @(negedge CLK);

        do_op(2'b11, 8'h81, 8'h01, 1'b0, 1'b0);
        do_op(2'b01, 8'h90, 8'h03, 1'b0, 1'b0);
        do_op(2'b00, 8'h90, 8'h03, 1'b0, 1'b0);
        do_op(2'b10, 8'h01, 8'h09, 1'b0, 1'b0);
        do_op(2'b00, 8'hFF, 8'hFC, 1'b0, 1'b0);
        do_op(2'b01, 8'h80, 8'h0F, 1'b0, 1'b0);
        do_op(2'b10, 8'hA5, 8'h00, 1'b0, 1'b0);

        do_op(2'b11, 8'h3C, 8'h04, 1'b1, 1'b0);

        do_op(2'b11, 8'h81, 8'h01, 1'b0, 1'b1);
        do_op(2'b10, 8'h5A, 8'h00, 1'b0, 1'b1);
        do_op(2'b01, 8'hC3, 8'h02, 1'b0, 1'b0);

        do_op(2'b10, 8'h01, 8'h01, 1'b0, 1'b0);
        START = 1'b1; INPUT = 8'h01; SHIFT_AMNT = 8'h07; SHIFTOP = 2'b11;
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        #2 RESET = 1'b1;
        #1;
        chk("abort_output", {24'd0, OUTPUT}, 32'd0);
        chk("abort_busy", {31'd0, BUSY}, 32'd0);
        done_seen = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            if (DONE === 1'b1) done_seen = 1'b1;
        end
        chk("abort_no_done", {31'd0, done_seen}, 32'd0);
        RESET = 1'b0;
        do_op(2'b11, 8'h01, 8'h02, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            chain = ($urandom % 4 == 0) && (i != 39);
            do_op(2'($urandom), 8'($urandom), 8'($urandom), ($urandom % 3 == 0), chain);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
